// File: rtl/elevator_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : elevator_request_unit
// Brief    : Debounced cabin/hall button latching with serve clearing and
//            above/below/here request summaries for the direction FSM.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module elevator_request_unit #(
    parameter int FLOORS          = 8,
    parameter int FLOOR_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               buttons_block,
    input  logic [FLOORS-1:0]  btn_in,
    input  logic [FLOORS-2:0]  btn_up_out,
    input  logic [FLOORS-1:1]  btn_down_out,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic               serve_valid,
    input  logic [FLOOR_W-1:0] serve_floor,
    input  logic [1:0]         serve_dir,
    output logic [FLOORS-1:0]  active_in_levels,
    output logic [FLOORS-2:0]  active_out_up_levels,
    output logic [FLOORS-1:1]  active_out_down_levels,
    output logic               req_above,
    output logic               req_below,
    output logic               req_here,
    output logic [CNT_W-1:0]   pending_count
);

    localparam int               NB        = 3 * FLOORS - 2;
    localparam logic [7:0]       c_DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       c_DB_MAX  = 8'(DEBOUNCE_CYCLES);
    localparam logic [FLOOR_W:0] c_FLOORS  = (FLOOR_W + 1)'(FLOORS);

    // Flattened button map: cabin [F-1:0], hall up [2F-2:F], hall down [3F-3:2F-1]
    logic [NB-1:0] w_raw;
    logic [NB-1:0] w_evt;
    logic [NB-1:0] w_acc;

    assign w_raw = {btn_down_out, btn_up_out, btn_in};

    generate
        for (genvar g = 0; g < NB; g++) begin : g_debounce
            logic [7:0] r_cnt;
            logic       r_arm;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= 8'd0;
                    r_arm <= 1'b0;
                end else if (!w_raw[g]) begin
                    r_cnt <= 8'd0;
                    r_arm <= 1'b1;
                end else if (r_arm) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_arm <= 1'b0;
                    end
                    if (r_cnt != c_DB_MAX) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            assign w_evt[g] = w_raw[g] & r_arm & (r_cnt == c_DB_LAST);
        end
    endgenerate

    // Blocked events are still consumed: the arm flag clears regardless
    assign w_acc = w_evt & {NB{~buttons_block}};

    logic [FLOORS-1:0] w_ev_in;
    logic [FLOORS-2:0] w_ev_up;
    logic [FLOORS-1:1] w_ev_dn;

    assign w_ev_in = w_acc[FLOORS-1:0];
    assign w_ev_up = w_acc[2*FLOORS-2:FLOORS];
    assign w_ev_dn = w_acc[NB-1:2*FLOORS-1];

    logic              w_serve_ok;
    logic [FLOORS-1:0] w_hit;
    logic [FLOORS-1:0] w_clr_in;
    logic [FLOORS-2:0] w_clr_up;
    logic [FLOORS-1:1] w_clr_dn;

    assign w_serve_ok = serve_valid & ({1'b0, serve_floor} < c_FLOORS);

    generate
        for (genvar g = 0; g < FLOORS; g++) begin : g_serve
            localparam logic [FLOOR_W-1:0] c_IDX = FLOOR_W'(g);
            assign w_hit[g] = w_serve_ok & (serve_floor == c_IDX);
        end
    endgenerate

    assign w_clr_in = w_hit;
    assign w_clr_up = w_hit[FLOORS-2:0] & {(FLOORS-1){serve_dir[0]}};
    assign w_clr_dn = w_hit[FLOORS-1:1] & {(FLOORS-1){serve_dir[1]}};

    logic [FLOORS-1:0] r_in;
    logic [FLOORS-2:0] r_up;
    logic [FLOORS-1:1] r_dn;

    // Serve is applied after the event so a colliding press is swallowed
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in <= '0;
            r_up <= '0;
            r_dn <= '0;
        end else begin
            r_in <= (r_in ^ w_ev_in) & ~w_clr_in;
            r_up <= (r_up | w_ev_up) & ~w_clr_up;
            r_dn <= (r_dn | w_ev_dn) & ~w_clr_dn;
        end
    end

    assign active_in_levels       = r_in;
    assign active_out_up_levels   = r_up;
    assign active_out_down_levels = r_dn;

    logic [FLOORS-1:0] w_floor_any;
    logic [FLOORS-1:0] w_above;
    logic [FLOORS-1:0] w_below;
    logic [FLOORS-1:0] w_here;

    generate
        for (genvar g = 0; g < FLOORS; g++) begin : g_summary
            localparam logic [FLOOR_W-1:0] c_IDX = FLOOR_W'(g);
            if (g == 0) begin : g_bottom
                assign w_floor_any[g] = r_in[g] | r_up[g];
            end else if (g == FLOORS - 1) begin : g_top
                assign w_floor_any[g] = r_in[g] | r_dn[g];
            end else begin : g_mid
                assign w_floor_any[g] = r_in[g] | r_up[g] | r_dn[g];
            end
            // An out-of-range current_floor lies above every floor, so all
            // active requests naturally fall into req_below
            assign w_above[g] = w_floor_any[g] & (c_IDX > current_floor);
            assign w_below[g] = w_floor_any[g] & (c_IDX < current_floor);
            assign w_here[g]  = w_floor_any[g] & (c_IDX == current_floor);
        end
    endgenerate

    assign req_above = |w_above;
    assign req_below = |w_below;
    assign req_here  = |w_here;

    logic [NB-1:0]    w_all;
    logic [CNT_W-1:0] w_count;

    assign w_all = {r_dn, r_up, r_in};

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NB; i++) begin
            w_count = w_count + CNT_W'(w_all[i]);
        end
    end

    assign pending_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_unit.sv
`default_nettype none
// Directed testbench for elevator_request_unit (8 floors, debounce of 4).
module tb_elevator_request_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       buttons_block;
    logic [7:0] btn_in;
    logic [6:0] btn_up_out;
    logic [7:1] btn_down_out;
    logic [2:0] current_floor;
    logic       serve_valid;
    logic [2:0] serve_floor;
    logic [1:0] serve_dir;
    logic [7:0] active_in_levels;
    logic [6:0] active_out_up_levels;
    logic [7:1] active_out_down_levels;
    logic       req_above;
    logic       req_below;
    logic       req_here;
    logic [4:0] pending_count;

    int total = 0;
    int bad   = 0;

    elevator_request_unit #(
        .FLOORS(8), .FLOOR_W(3), .DEBOUNCE_CYCLES(4), .CNT_W(5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .buttons_block          (buttons_block),
        .btn_in                 (btn_in),
        .btn_up_out             (btn_up_out),
        .btn_down_out           (btn_down_out),
        .current_floor          (current_floor),
        .serve_valid            (serve_valid),
        .serve_floor            (serve_floor),
        .serve_dir              (serve_dir),
        .active_in_levels       (active_in_levels),
        .active_out_up_levels   (active_out_up_levels),
        .active_out_down_levels (active_out_down_levels),
        .req_above              (req_above),
        .req_below              (req_below),
        .req_here               (req_here),
        .pending_count          (pending_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // kind: 0 = cabin, 1 = hall up, 2 = hall down; held exactly 4 edges
    task automatic press(input int kind, input int idx);
        if (kind == 0) btn_in[idx] = 1'b1;
        else if (kind == 1) btn_up_out[idx] = 1'b1;
        else btn_down_out[idx] = 1'b1;
        tick(4);
        if (kind == 0) btn_in[idx] = 1'b0;
        else if (kind == 1) btn_up_out[idx] = 1'b0;
        else btn_down_out[idx] = 1'b0;
        tick(1);
    endtask

    task automatic serve(input int fl, input logic [1:0] dir);
        serve_valid = 1'b1;
        serve_floor = 3'(fl);
        serve_dir   = dir;
        tick(1);
        serve_valid = 1'b0;
        serve_dir   = 2'b00;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        total++;
        if ({active_in_levels, active_out_up_levels, active_out_down_levels} !== 22'd0) begin
            bad++;
            $display("FAIL reset_active got=%h want=0",
                     {active_in_levels, active_out_up_levels, active_out_down_levels});
        end
        total++;
        if ({req_above, req_below, req_here} !== 3'b000 || pending_count !== 5'd0) begin
            bad++;
            $display("FAIL reset_summary got=%b/%0d want=000/0",
                     {req_above, req_below, req_here}, pending_count);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_debounce;
        btn_in[5] = 1'b1;
        tick(3);
        total++;
        if (active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL debounce_early got=%h want=00", active_in_levels);
        end
        tick(1);
        total++;
        if (active_in_levels !== 8'h20) begin
            bad++;
            $display("FAIL debounce_fourth got=%h want=20", active_in_levels);
        end
        btn_in[5] = 1'b0;
        tick(1);
        btn_in[6] = 1'b1;
        tick(3);
        btn_in[6] = 1'b0;
        tick(3);
        total++;
        if (active_in_levels !== 8'h20) begin
            bad++;
            $display("FAIL debounce_short got=%h want=20", active_in_levels);
        end
        serve(5, 2'b00);
        total++;
        if (active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL serve_cabin got=%h want=00", active_in_levels);
        end
    endtask

    task automatic test_toggle;
        press(0, 2);
        total++;
        if (active_in_levels !== 8'h04) begin
            bad++;
            $display("FAIL toggle_on got=%h want=04", active_in_levels);
        end
        press(0, 2);
        total++;
        if (active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL toggle_off got=%h want=00", active_in_levels);
        end
        btn_in[2] = 1'b1;
        tick(20);
        btn_in[2] = 1'b0;
        tick(1);
        total++;
        if (active_in_levels !== 8'h04) begin
            bad++;
            $display("FAIL toggle_hold got=%h want=04", active_in_levels);
        end
        serve(2, 2'b00);
    endtask

    task automatic test_hall_serve;
        logic [7:1] exp_dn;
        exp_dn    = '0;
        exp_dn[3] = 1'b1;
        press(1, 3);
        press(2, 3);
        press(0, 3);
        press(1, 3);
        total++;
        if (active_out_up_levels !== 7'h08 || active_out_down_levels !== exp_dn
            || active_in_levels !== 8'h08) begin
            bad++;
            $display("FAIL hall_latch got=%h/%h/%h want=08/%h/08",
                     active_out_up_levels, active_out_down_levels, active_in_levels, exp_dn);
        end
        serve(3, 2'b01);
        total++;
        if (active_out_up_levels !== 7'h00 || active_out_down_levels !== exp_dn
            || active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL serve_up got=%h/%h/%h want=00/%h/00",
                     active_out_up_levels, active_out_down_levels, active_in_levels, exp_dn);
        end
        serve(3, 2'b10);
        total++;
        if (active_out_down_levels !== 7'h00) begin
            bad++;
            $display("FAIL serve_down got=%h want=00", active_out_down_levels);
        end
        press(1, 6);
        serve(7, 2'b11);
        total++;
        if (active_out_up_levels !== 7'h40) begin
            bad++;
            $display("FAIL serve_top got=%h want=40", active_out_up_levels);
        end
        serve(6, 2'b01);
    endtask

    task automatic test_collision;
        btn_up_out[1] = 1'b1;
        btn_in[4]     = 1'b1;
        tick(3);
        serve(1, 2'b01);
        total++;
        if (active_out_up_levels !== 7'h00 || active_in_levels !== 8'h10) begin
            bad++;
            $display("FAIL collision got=%h/%h want=00/10",
                     active_out_up_levels, active_in_levels);
        end
        tick(5);
        btn_up_out[1] = 1'b0;
        btn_in[4]     = 1'b0;
        tick(2);
        total++;
        if (active_out_up_levels !== 7'h00) begin
            bad++;
            $display("FAIL collision_defer got=%h want=00", active_out_up_levels);
        end
        serve(4, 2'b00);
    endtask

    task automatic test_block;
        buttons_block = 1'b1;
        btn_in[0]     = 1'b1;
        tick(6);
        buttons_block = 1'b0;
        tick(6);
        total++;
        if (active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL block_hold got=%h want=00", active_in_levels);
        end
        btn_in[0] = 1'b0;
        tick(1);
        press(0, 0);
        total++;
        if (active_in_levels !== 8'h01) begin
            bad++;
            $display("FAIL block_repress got=%h want=01", active_in_levels);
        end
        buttons_block = 1'b1;
        serve(0, 2'b00);
        buttons_block = 1'b0;
        total++;
        if (active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL block_serve got=%h want=00", active_in_levels);
        end
    endtask

    task automatic test_summary;
        press(0, 6);
        press(1, 2);
        press(2, 4);
        current_floor = 3'd4;
        #1;
        total++;
        if ({req_above, req_below, req_here} !== 3'b111 || pending_count !== 5'd3) begin
            bad++;
            $display("FAIL summary_f4 got=%b/%0d want=111/3",
                     {req_above, req_below, req_here}, pending_count);
        end
        current_floor = 3'd7;
        #1;
        total++;
        if ({req_above, req_below, req_here} !== 3'b010) begin
            bad++;
            $display("FAIL summary_f7 got=%b want=010", {req_above, req_below, req_here});
        end
        current_floor = 3'd2;
        #1;
        total++;
        if ({req_above, req_below, req_here} !== 3'b101) begin
            bad++;
            $display("FAIL summary_f2 got=%b want=101", {req_above, req_below, req_here});
        end
        serve(6, 2'b00);
        serve(2, 2'b01);
        serve(4, 2'b10);
        total++;
        if (pending_count !== 5'd0 || {req_above, req_below, req_here} !== 3'b000) begin
            bad++;
            $display("FAIL summary_clear got=%0d/%b want=0/000",
                     pending_count, {req_above, req_below, req_here});
        end
    endtask

    task automatic test_held_reset;
        btn_in[1] = 1'b1;
        reset     = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(8);
        total++;
        if (active_in_levels !== 8'h00) begin
            bad++;
            $display("FAIL held_reset got=%h want=00", active_in_levels);
        end
        btn_in[1] = 1'b0;
        tick(1);
        press(0, 1);
        total++;
        if (active_in_levels !== 8'h02) begin
            bad++;
            $display("FAIL held_repress got=%h want=02", active_in_levels);
        end
    endtask

    initial begin
        reset         = 1'b1;
        buttons_block = 1'b0;
        btn_in        = '0;
        btn_up_out    = '0;
        btn_down_out  = '0;
        current_floor = '0;
        serve_valid   = 1'b0;
        serve_floor   = '0;
        serve_dir     = 2'b00;
        test_reset();
        test_debounce();
        test_toggle();
        test_hall_serve();
        test_collision();
        test_block();
        test_summary();
        test_held_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_request_unit.md
Name: elevator_request_unit

Overview:
- Parametrised successor of the cabin/hall button request register for the elevator controller.
- Converts raw cabin and hall (up/down) buttons into latched per-floor requests, with per-button debounce and one-shot press detection.
- Cabin requests can be cancelled; hall requests are cleared by the motion controller's serve pulse.
- Provides above/below/here request summaries and a pending-request count to the direction-selection FSM.

Parameters:
FLOORS, 8, number of floors (2..16)
FLOOR_W, 3, width of floor index; must satisfy 2^FLOOR_W >= FLOORS
DEBOUNCE_CYCLES, 4, consecutive high samples needed to accept a press (1..255)
CNT_W, 5, width of pending_count; must hold 3*FLOORS-2

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
buttons_block  in  1  1 = discard new press events (serve still works)
btn_in  in  FLOORS  raw cabin buttons, bit i = floor i
btn_up_out  in  FLOORS-1  raw hall up buttons, floors 0..FLOORS-2
btn_down_out  in  FLOORS-1  raw hall down buttons, floors 1..FLOORS-1 (vector index 1..FLOORS-1)
current_floor  in  FLOOR_W  cabin position from the motion controller
serve_valid  in  1  one-cycle pulse: cabin stopped and doors opened at serve_floor
serve_floor  in  FLOOR_W  floor being served
serve_dir  in  2  bit0 = clear hall up, bit1 = clear hall down
active_in_levels  out  FLOORS  latched cabin requests
active_out_up_levels  out  FLOORS-1  latched hall up requests
active_out_down_levels  out  FLOORS-1  latched hall down requests, index 1..FLOORS-1
req_above  out  1  any active request at a floor > current_floor
req_below  out  1  any active request at a floor < current_floor
req_here  out  1  any active request at current_floor
pending_count  out  CNT_W  popcount of all three active vectors

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - All active vectors = 0; req_above/req_below/req_here = 0; pending_count = 0.
  - Every debounce counter = 0; every arm flag = 0.
- Debounce, per button (3*FLOORS-2 instances):
  - Arm flag sets on any cycle the raw input is sampled 0.
  - While armed and input is 1, the counter increments, saturating at DEBOUNCE_CYCLES.
  - A sample of 0 clears the counter.
  - Press event fires when armed, input is 1 and counter == DEBOUNCE_CYCLES-1. The event clears the arm flag, so exactly one event is generated per press.
  - Timing: input high on edges k..k+D-1 (D = DEBOUNCE_CYCLES) gives the active bit updated at edge k+D-1. D=1 is plain rising-edge detection.
  - A button held across reset release produces no event until it is released and pressed again.
- buttons_block = 1:
  - Press events are consumed and discarded; the arm flag still clears.
  - A button held through unblock does not fire.
- Cabin press event: toggles active_in_levels[i] (0→1 request, 1→0 cancel).
- Hall press event: sets the bit; a second press while the bit is set has no effect.
- Serve (serve_valid=1):
  - Clears active_in_levels[serve_floor].
  - Clears up[serve_floor] if serve_dir[0]; clears down[serve_floor] if serve_dir[1].
  - Nonexistent bits (up at top floor, down at floor 0) are ignored.
  - serve_floor >= FLOORS: the whole serve is ignored.
- Simultaneous serve and press event on the same bit: serve wins, bit = 0 after the edge, and the press event is consumed (not deferred). Events on other bits are unaffected.
- Summary outputs:
  - Combinational from the registered active vectors and current_floor only; no path from raw buttons or serve inputs.
  - current_floor >= FLOORS: req_above = 0, req_here = 0, req_below = any active bit.
- Active outputs change only on rising edges.

Test Plan:
- D=4: btn_in[5] high for 4 cycles → active_in_levels[5]=1 after the 4th edge. Same input high for 3 cycles then low → no change.
- Cabin toggle: two debounced presses on floor 2 → bit 0→1→0. Hold the button high for 20 cycles → exactly one toggle.
- Hall up at floor 3 and down at floor 3 latched; serve_valid, floor 3, dir=01 → up[3]=0, down[3]=1, in[3]=0. Then dir=10 → down[3]=0.
- Same-cycle collision: press event on up[1] in the cycle serve_valid floor 1 dir=01 → up[1]=0 afterwards, and no later set without a new press.
- buttons_block=1 during a press of btn_in[0] held through unblock → active_in_levels stays 0. After release and re-press → 1. A serve during block still clears.
- current_floor=4 with in[6], up[2], down[4] active → req_above=1, req_below=1, req_here=1, pending_count=3. Button held across reset deassert → no request until release and re-press.
